vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port synchronous video RAM between VGA scan-out reads and CPU rd_vram/wr_vram accesses.
//  VGA has absolute priority every cycle. The CPU gets idle slots through a latched request/ready handshake.
//  Sits between the multi-cycle CPU, the display controller and the VRAM block, inside top.
// PARAMETERS
//  ADDR_W     13   VRAM word-address width
//  DATA_W     16   VRAM word width
//  STARVE_MAX 255  CPU wait cycles before cpu_starved sets (saturating counter limit)
// PORTS
//  clk          in   1       system clock; all logic rises on posedge clk
//  rst_n        in   1       asynchronous, active-low reset
//  vga_req      in   1       VGA fetch request this cycle (single-cycle, no hold)
//  vga_addr     in   ADDR_W  VGA fetch address
//  vga_data     out  DATA_W  VGA fetch data
//  vga_valid    out  1       vga_data valid (exactly 1 cycle after vga_req)
//  cpu_rd       in   1       CPU read request (level)
//  cpu_wr       in   1       CPU write request (level; wins if both are high)
//  cpu_addr     in   ADDR_W  CPU address, sampled on accept
//  cpu_wdata    in   DATA_W  CPU write data, sampled on accept
//  cpu_rdata    out  DATA_W  CPU read data; held until the next read completes
//  cpu_ready    out  1       1-cycle completion pulse for a read or a write
//  cpu_starved  out  1       sticky: a CPU request waited >= STARVE_MAX cycles; cleared by reset only
//  mem_addr     out  ADDR_W  VRAM address
//  mem_we       out  1       VRAM write enable
//  mem_wdata    out  DATA_W  VRAM write data
//  mem_rdata    in   DATA_W  VRAM read data, 1-cycle latency after mem_addr
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0, including mem_we, cpu_rdata, vga_data, cpu_starved.
//  CPU FSM:
//   - IDLE: on cpu_rd|cpu_wr, latch addr, wdata and op (wr if cpu_wr) -> PEND; wait_cnt=0.
//   - PEND: if !vga_req, drive the latched access onto mem_* (mem_we=op_wr) -> ISSUE.
//     Else stay in PEND; wait_cnt += 1, saturating at STARVE_MAX; cpu_starved sets at STARVE_MAX.
//   - ISSUE: read -> cpu_rdata<=mem_rdata. cpu_ready=1 for this cycle, read or write -> IDLE.
//  Handshake:
//   - Worst-case latency from accept to cpu_ready is 2 cycles plus any VGA-occupied cycles.
//   - A request still high in the cycle after cpu_ready is a new request.
//   - Requests arriving outside IDLE are ignored.
//  VGA path:
//   - vga_req=1: mem_addr=vga_addr, mem_we=0, regardless of CPU state. No VGA request is ever delayed or dropped.
//   - Next cycle: vga_valid=1, vga_data<=mem_rdata. Otherwise vga_valid=0 and vga_data holds.
//  mem_* are combinational from the grant decision and latched registers.
//  Idle slot (no VGA, CPU not in PEND): mem_addr=0, mem_we=0.
//  Data tag: a 1-bit register records who owns the read issued last cycle. mem_rdata never goes to both sides.
//  Back-to-back vga_req every cycle: the CPU stays in PEND indefinitely; only cpu_starved reports it.
//  Writes never drive VGA outputs. A CPU write and a VGA read never share a cycle.
//  Reset mid-access: a pending or issued access is abandoned.
//   - No cpu_ready pulse. A write not yet in ISSUE never reaches VRAM.
// STRUCTURE
//  Shared `define include soc_defs.vh holds:
//   - FSM encodings ARB_IDLE, ARB_PEND, ARB_ISSUE
//   - VRAM_ADDR_W and VRAM_DATA_W defaults (shared with the display controller)
//  Flat module; no sub-module. Grant logic is one always @* block; FSM and counters are one clocked block.
// TESTING
//  1. Reset 3 cycles, then idle -> all outputs 0, mem_we=0.
//  2. CPU write 0x0123 -> 0xBEEF with no VGA -> mem_we=1 at 0x0123 1 cycle after accept; cpu_ready pulse 1 cycle later.
//  3. CPU read of 0x0123 during a 4-cycle VGA burst (0x0000..0x0003):
//     - vga_valid 4 pulses with the correct data
//     - CPU issues in the first free cycle; cpu_rdata=0xBEEF with cpu_ready
//  4. vga_req high 300 cycles with a CPU read pending -> cpu_starved=1 after 255 waits; read completes after the VGA burst.
//  5. cpu_rd and cpu_wr high together -> write performed; cpu_rdata unchanged.
//  6. rst_n low while in PEND (write) -> no mem_we, no cpu_ready. After release, a new request completes normally.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default sizes for the VRAM arbiter and the display controller.
package vram_arbiter_pkg;

  localparam int DEF_ADDR_W     = 13;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PEND  = 2'd1,
    ARB_ISSUE = 2'd2
  } arb_state_t;

  // Owner of the read that went to VRAM last cycle; TAG_CPU also covers idle slots.
  typedef enum logic {
    TAG_CPU = 1'b0,
    TAG_VGA = 1'b1
  } rd_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of VGA, CPU and VRAM signals around the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = vram_arbiter_pkg::DEF_DATA_W
) ();

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;

  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_starved;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // The arbiter itself.
  modport slave (
    input  vga_req, vga_addr, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, vga_valid, cpu_rdata, cpu_ready, cpu_starved,
           mem_addr, mem_we, mem_wdata
  );

  // The clients and the VRAM block around it.
  modport master (
    output vga_req, vga_addr, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, vga_valid, cpu_rdata, cpu_ready, cpu_starved,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between VGA scan-out (absolute priority) and
// CPU accesses, which are latched and slotted into cycles VGA leaves free.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  vram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_next;
  rd_tag_t           rd_tag;
  logic              op_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  wait_cnt;
  logic              starved_q;
  logic [DATA_W-1:0] vga_data_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_accept;
  logic              cpu_grant;
  logic              cpu_capture;

  // Grant decision: VGA always owns the port when it asks; the CPU only gets it from PEND.
  always_comb begin
    state_next    = state;
    cpu_accept    = 1'b0;
    cpu_grant     = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;

    case (state)
      ARB_IDLE: begin
        if (bus.cpu_rd || bus.cpu_wr) begin
          cpu_accept = 1'b1;
          state_next = ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (!bus.vga_req) begin
          cpu_grant  = 1'b1;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        bus.cpu_ready = 1'b1;
        state_next    = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase

    if (bus.vga_req) begin
      bus.mem_addr = bus.vga_addr;
    end else if (cpu_grant) begin
      bus.mem_addr  = lat_addr;
      bus.mem_we    = op_wr;
      bus.mem_wdata = lat_wdata;
    end
  end

  // ISSUE always follows a CPU-owned slot, so the tag can never also point at VGA here.
  assign cpu_capture = (state == ARB_ISSUE) && !op_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rd_tag      <= TAG_CPU;
      op_wr       <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      starved_q   <= 1'b0;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state  <= state_next;
      rd_tag <= bus.vga_req ? TAG_VGA : TAG_CPU;

      if (cpu_accept) begin
        op_wr     <= bus.cpu_wr;
        lat_addr  <= bus.cpu_addr;
        lat_wdata <= bus.cpu_wdata;
        wait_cnt  <= '0;
      end else if ((state == ARB_PEND) && bus.vga_req) begin
        if (wait_cnt < CNT_W'(STARVE_MAX)) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt >= CNT_W'(STARVE_MAX - 1)) begin
          starved_q <= 1'b1;
        end
      end

      if (rd_tag == TAG_VGA) begin
        vga_data_q <= bus.mem_rdata;
      end
      if (cpu_capture) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Read data is bypassed in its delivery cycle and held in the registers afterwards.
  assign bus.vga_valid   = (rd_tag == TAG_VGA);
  assign bus.vga_data    = (rd_tag == TAG_VGA) ? bus.mem_rdata : vga_data_q;
  assign bus.cpu_rdata   = cpu_capture ? bus.mem_rdata : cpu_rdata_q;
  assign bus.cpu_starved = starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_arbiter;

  logic clk;
  logic rst_n;
  logic ram_init;
  int   total;
  int   bad;

  logic [15:0] vram [0:8191];

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM, read-before-write; preloaded once during the first reset.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 8192; i++) begin
        vram[i] <= (i < 4) ? 16'(16'h1000 + i) : 16'h0000;
      end
    end else begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= vram[bus.mem_addr];
    end
  end

  task automatic idle_inputs();
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ram_init = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus.vga_valid, bus.cpu_ready, bus.cpu_starved, bus.mem_we} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got vga_valid/cpu_ready/starved/we=%b want 0000",
               {bus.vga_valid, bus.cpu_ready, bus.cpu_starved, bus.mem_we});
    end
    total++;
    if (bus.vga_data !== 16'h0 || bus.cpu_rdata !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got vga_data=%h cpu_rdata=%h want 0000", bus.vga_data, bus.cpu_rdata);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    ram_init = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus.mem_addr !== 13'h0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 16'h0 || bus.cpu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_slot: got addr=%h we=%b wdata=%h ready=%b want 0 0 0 0",
               bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.cpu_ready);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0123; bus.cpu_wdata = 16'hBEEF;
    #1;
    total++;
    if (bus.mem_we !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_accept: got we=%b ready=%b want 0 0", bus.mem_we, bus.cpu_ready);
    end
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = 16'h0000;
    #1;
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'h0123 || bus.mem_wdata !== 16'hBEEF || bus.cpu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_issue: got we=%b addr=%h wdata=%h ready=%b want 1 0123 beef 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ready);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.vga_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_ready: got ready=%b we=%b vga_valid=%b want 1 0 0",
               bus.cpu_ready, bus.mem_we, bus.vga_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b0 || vram[13'h0123] !== 16'hBEEF || bus.cpu_rdata !== 16'h0) begin
      bad++;
      $display("[TB] FAIL write_done: got ready=%b vram=%h cpu_rdata=%h want 0 beef 0000",
               bus.cpu_ready, vram[13'h0123], bus.cpu_rdata);
    end
  endtask

  task automatic test_vga_burst_read();
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_addr = 13'h0123;
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0000;
    #1;
    total++;
    if (bus.mem_addr !== 13'h0000 || bus.mem_we !== 1'b0 || bus.vga_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL burst_first: got addr=%h we=%b vga_valid=%b want 0000 0 0",
               bus.mem_addr, bus.mem_we, bus.vga_valid);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.cpu_rd = 1'b0; bus.vga_addr = 13'(k);
      #1;
      total++;
      if (bus.mem_addr !== 13'(k) || bus.vga_valid !== 1'b1 || bus.vga_data !== 16'(16'h1000 + k - 1) || bus.cpu_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL burst_%0d: got addr=%h valid=%b data=%h ready=%b want %h 1 %h 0",
                 k, bus.mem_addr, bus.vga_valid, bus.vga_data, bus.cpu_ready, 13'(k), 16'(16'h1000 + k - 1));
      end
    end
    @(negedge clk);
    bus.vga_req = 1'b0; bus.vga_addr = 13'h0;
    #1;
    total++;
    if (bus.mem_addr !== 13'h0123 || bus.mem_we !== 1'b0 || bus.vga_valid !== 1'b1 || bus.vga_data !== 16'h1003) begin
      bad++;
      $display("[TB] FAIL burst_cpu_slot: got addr=%h we=%b valid=%b data=%h want 0123 0 1 1003",
               bus.mem_addr, bus.mem_we, bus.vga_valid, bus.vga_data);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hBEEF || bus.vga_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL burst_cpu_ready: got ready=%b rdata=%h vga_valid=%b want 1 beef 0",
               bus.cpu_ready, bus.cpu_rdata, bus.vga_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 16'hBEEF || bus.vga_data !== 16'h1003 || bus.cpu_starved !== 1'b0) begin
      bad++;
      $display("[TB] FAIL burst_hold: got ready=%b rdata=%h vga_data=%h starved=%b want 0 beef 1003 0",
               bus.cpu_ready, bus.cpu_rdata, bus.vga_data, bus.cpu_starved);
    end
  endtask

  task automatic test_starve();
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_addr = 13'h0002;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      bus.cpu_rd = 1'b0; bus.vga_req = 1'b1; bus.vga_addr = 13'(i % 4);
      #1;
      total++;
      if (bus.mem_addr !== 13'(i % 4) || bus.mem_we !== 1'b0 || bus.cpu_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL starve_block_%0d: got addr=%h we=%b ready=%b want %h 0 0",
                 i, bus.mem_addr, bus.mem_we, bus.cpu_ready, 13'(i % 4));
      end
      if (i >= 2) begin
        total++;
        if (bus.vga_valid !== 1'b1 || bus.vga_data !== 16'(16'h1000 + (i - 1) % 4)) begin
          bad++;
          $display("[TB] FAIL starve_vga_%0d: got valid=%b data=%h want 1 %h",
                   i, bus.vga_valid, bus.vga_data, 16'(16'h1000 + (i - 1) % 4));
        end
      end
      if (i == 255) begin
        total++;
        if (bus.cpu_starved !== 1'b0) begin
          bad++;
          $display("[TB] FAIL starve_254_waits: got starved=%b want 0", bus.cpu_starved);
        end
      end
      if (i == 256) begin
        total++;
        if (bus.cpu_starved !== 1'b1) begin
          bad++;
          $display("[TB] FAIL starve_255_waits: got starved=%b want 1", bus.cpu_starved);
        end
      end
    end
    @(negedge clk);
    bus.vga_req = 1'b0; bus.vga_addr = 13'h0;
    #1;
    total++;
    if (bus.mem_addr !== 13'h0002 || bus.mem_we !== 1'b0 || bus.vga_data !== 16'h1000) begin
      bad++;
      $display("[TB] FAIL starve_issue: got addr=%h we=%b vga_data=%h want 0002 0 1000",
               bus.mem_addr, bus.mem_we, bus.vga_data);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'h1002 || bus.vga_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL starve_ready: got ready=%b rdata=%h vga_valid=%b want 1 1002 0",
               bus.cpu_ready, bus.cpu_rdata, bus.vga_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_starved !== 1'b1 || bus.cpu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL starve_sticky: got starved=%b ready=%b want 1 0", bus.cpu_starved, bus.cpu_ready);
    end
  endtask

  task automatic test_both_ops();
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0040; bus.cpu_wdata = 16'h5A5A;
    @(negedge clk);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    #1;
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'h0040 || bus.mem_wdata !== 16'h5A5A) begin
      bad++;
      $display("[TB] FAIL both_write: got we=%b addr=%h wdata=%h want 1 0040 5a5a",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'h1002) begin
      bad++;
      $display("[TB] FAIL both_ready: got ready=%b rdata=%h want 1 1002", bus.cpu_ready, bus.cpu_rdata);
    end
    @(negedge clk);
    #1;
    total++;
    if (vram[13'h0040] !== 16'h5A5A || bus.cpu_rdata !== 16'h1002) begin
      bad++;
      $display("[TB] FAIL both_effect: got vram=%h rdata=%h want 5a5a 1002", vram[13'h0040], bus.cpu_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0077; bus.cpu_wdata = 16'h1111;
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0000;
    @(negedge clk);
    bus.cpu_wr = 1'b0;
    #1;
    total++;
    if (bus.mem_we !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rmid_pend: got we=%b ready=%b want 0 0", bus.mem_we, bus.cpu_ready);
    end
    rst_n = 1'b0;
    bus.vga_req = 1'b0;
    #1;
    total++;
    if (bus.cpu_starved !== 1'b0 || bus.cpu_rdata !== 16'h0 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rmid_async: got starved=%b rdata=%h we=%b want 0 0000 0",
               bus.cpu_starved, bus.cpu_rdata, bus.mem_we);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.mem_we !== 1'b0 || bus.cpu_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rmid_after_%0d: got we=%b ready=%b want 0 0", k, bus.mem_we, bus.cpu_ready);
      end
    end
    total++;
    if (vram[13'h0077] !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL rmid_no_write: got vram=%h want 0000", vram[13'h0077]);
    end
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_addr = 13'h0040;
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    #1;
    total++;
    if (bus.mem_addr !== 13'h0040 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rmid_new_issue: got addr=%h we=%b want 0040 0", bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'h5A5A) begin
      bad++;
      $display("[TB] FAIL rmid_new_ready: got ready=%b rdata=%h want 1 5a5a", bus.cpu_ready, bus.cpu_rdata);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write();
    test_vga_burst_read();
    test_starve();
    test_both_ops();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
